fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Consumer side of the PC generator: reads PC/order, fetches the aligned FETCH_WIDTH-instruction
//  block containing PC from imem and pushes instructions into the instruction queue.
//  Returns move_pc/move_amount so the PC generator advances by exactly the number of
//  instructions accepted. Br_valid (redirect) flushes in-flight and buffered fetch data.
// PARAMETERS
//  FETCH_WIDTH  4  instructions per imem block; power of 2, 1..8; block = FETCH_WIDTH*4 bytes
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous reset, active-high
//  PC            in   32                current PC from PC generator
//  order         in   64                order of instruction at PC
//  Br_valid      in   1                 redirect this cycle; PC generator loads Br_PC next edge
//  move_pc       out  1                 advance PC this cycle
//  move_amount   out  4                 instructions accepted this cycle (1..FETCH_WIDTH when move_pc)
//  imem_addr     out  32                block-aligned fetch address
//  imem_rmask    out  4                 4'hF for exactly one cycle per request, else 0
//  imem_rdata    in   FETCH_WIDTH*32    block data, slot i at bits [32*i+:32]
//  imem_resp     in   1                 one-cycle response strobe, rdata valid
//  iq_space      in   4                 free IQ entries this cycle
//  iq_push       out  1                 push iq_count instructions this cycle
//  iq_count      out  4                 number of instructions pushed (== move_amount)
//  iq_inst       out  FETCH_WIDTH*32    pushed instructions, slot 0 = instruction at PC
//  iq_pc         out  32                PC of slot 0
//  iq_order      out  64                order of slot 0; slot k has iq_order+k, pc iq_pc+4k
// BEHAVIOUR
//  - off = PC[2+:log2(FETCH_WIDTH)]; avail = FETCH_WIDTH - off; blk = PC with low
//    log2(FETCH_WIDTH)+2 bits cleared. n = min(avail, iq_space).
//  - States: IDLE, WAIT, DISCARD, DRAIN. Reset -> IDLE, buffer invalid; all outputs 0
//    (imem_addr 0, imem_rmask 0, move_pc 0, iq_push 0).
//  - IDLE: if !Br_valid && iq_space!=0: imem_rmask=4'hF, imem_addr=blk, latch blk as tag -> WAIT.
//    iq_space==0 or Br_valid: no request, stay IDLE. imem_resp in IDLE ignored.
//  - WAIT: imem_rmask=0. On imem_resp: latch imem_rdata into line buffer -> DRAIN (no push
//    in the resp cycle). Br_valid without resp -> DISCARD. Br_valid with resp -> drop data, IDLE.
//  - DISCARD: wait for the stale resp, drop it -> IDLE. No push, no move_pc.
//  - DRAIN: if blk==tag && n!=0 && !Br_valid: iq_push=move_pc=1, iq_count=move_amount=n,
//    iq_inst slot k = buffer[off+k] for k<n (slots >=n are don't-care), iq_pc=PC,
//    iq_order=order. If n==avail -> IDLE (block exhausted); else stay DRAIN.
//    n==0 (IQ full): hold, no push. blk!=tag (defensive): -> IDLE.
//    Br_valid: no push, no move_pc, invalidate buffer -> IDLE.
//  - Br_valid has priority over every push: move_pc and iq_push are forced 0 that cycle
//    (matches PC generator priority; redirected order comes from Br_order+1).
//  - One outstanding imem request max; next request issued no earlier than the cycle after
//    leaving DRAIN/DISCARD (IDLE cycle). Latency PC->first push: request cycle + memory
//    latency + 1 cycle.
//  - iq_count/move_amount never exceed iq_space or avail; width 4 bits, no wrap.
//  - rst in any state: next cycle IDLE, buffer invalid; a response arriving after reset
//    lands in IDLE and is ignored.
// TESTING
//  1. Reset, PC=0x1eceb000, FW=4, iq_space=8, resp after 3 cycles -> one push count 4,
//     iq_pc 0x1eceb000, iq_order 0, move_amount 4; next request addr 0x1eceb010.
//  2. PC=0x1eceb008 (off 2), iq_space=8 -> push count 2, slots = rdata words 2,3; back to IDLE.
//  3. PC off 0, iq_space=1 in DRAIN -> four pushes of count 1 on consecutive cycles,
//     iq_order 0,1,2,3; iq_space=0 cycle inserted -> no push, stays DRAIN.
//  4. Br_valid while WAIT -> DISCARD; stale resp dropped (no iq_push); new request issued
//     at redirected block one cycle later.
//  5. Br_valid same cycle as imem_resp, and Br_valid during DRAIN -> no push, move_pc=0,
//     state IDLE next cycle.
//  6. rst asserted in WAIT, resp arrives 2 cycles later -> ignored, no push, outputs stay 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundles the PC-generator, instruction-memory and instruction-queue signals of the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
   parameter int FETCH_WIDTH = 4
);
   logic [31:0]               PC;
   logic [63:0]               order;
   logic                      Br_valid;
   logic                      move_pc;
   logic [3:0]                move_amount;
   logic [31:0]               imem_addr;
   logic [3:0]                imem_rmask;
   logic [FETCH_WIDTH*32-1:0] imem_rdata;
   logic                      imem_resp;
   logic [3:0]                iq_space;
   logic                      iq_push;
   logic [3:0]                iq_count;
   logic [FETCH_WIDTH*32-1:0] iq_inst;
   logic [31:0]               iq_pc;
   logic [63:0]               iq_order;

   modport master (
      input  PC, order, Br_valid, imem_rdata, imem_resp, iq_space,
      output move_pc, move_amount, imem_addr, imem_rmask,
             iq_push, iq_count, iq_inst, iq_pc, iq_order
   );

   modport slave (
      output PC, order, Br_valid, imem_rdata, imem_resp, iq_space,
      input  move_pc, move_amount, imem_addr, imem_rmask,
             iq_push, iq_count, iq_inst, iq_pc, iq_order
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetches the aligned instruction block holding PC, buffers it, and drains it into the
// instruction queue as space allows, telling the PC generator how far to advance.
module fetch_unit #(
   parameter int FETCH_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);
   localparam logic [31:0] BLK_MASK = 32'(FETCH_WIDTH * 4 - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD, DRAIN} state_t;

   state_t                    state;
   state_t                    state_next;
   logic [31:0]               tag;
   logic [FETCH_WIDTH*32-1:0] line_buf;
   logic                      buf_valid;

   logic [31:0] blk;
   logic [3:0]  off;
   logic [3:0]  avail;
   logic [3:0]  n;
   logic        issue;
   logic        capture;
   logic        invalidate;

   // Position of PC inside its block and how many instructions can go out this cycle.
   always_comb begin
      blk   = bus.PC & ~BLK_MASK;
      off   = 4'((bus.PC >> 2) & 32'(FETCH_WIDTH - 1));
      avail = 4'(FETCH_WIDTH) - off;
      n     = (bus.iq_space < avail) ? bus.iq_space : avail;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tag       <= '0;
         line_buf  <= '0;
         buf_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (issue)
            tag <= blk;
         if (capture) begin
            line_buf  <= bus.imem_rdata;
            buf_valid <= 1'b1;
         end else if (invalidate) begin
            buf_valid <= 1'b0;
         end
      end
   end

   // A redirect always wins over a push, so the PC generator never sees both in one cycle.
   always_comb begin
      state_next      = state;
      issue           = 1'b0;
      capture         = 1'b0;
      invalidate      = 1'b0;
      bus.move_pc     = 1'b0;
      bus.move_amount = 4'd0;
      bus.imem_addr   = 32'd0;
      bus.imem_rmask  = 4'h0;
      bus.iq_push     = 1'b0;
      bus.iq_count    = 4'd0;
      bus.iq_inst     = '0;
      bus.iq_pc       = 32'd0;
      bus.iq_order    = 64'd0;

      if (!rst) begin
         case (state)
            IDLE: begin
               if (!bus.Br_valid && bus.iq_space != 4'd0) begin
                  bus.imem_rmask = 4'hF;
                  bus.imem_addr  = blk;
                  issue          = 1'b1;
                  state_next     = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_resp) begin
                  if (bus.Br_valid) begin
                     state_next = IDLE;
                  end else begin
                     capture    = 1'b1;
                     state_next = DRAIN;
                  end
               end else if (bus.Br_valid) begin
                  state_next = DISCARD;
               end
            end
            DISCARD: begin
               if (bus.imem_resp)
                  state_next = IDLE;
            end
            DRAIN: begin
               if (bus.Br_valid || !buf_valid || blk != tag) begin
                  invalidate = 1'b1;
                  state_next = IDLE;
               end else if (n != 4'd0) begin
                  bus.move_pc     = 1'b1;
                  bus.move_amount = n;
                  bus.iq_push     = 1'b1;
                  bus.iq_count    = n;
                  bus.iq_inst     = line_buf >> {off, 5'b00000};
                  bus.iq_pc       = bus.PC;
                  bus.iq_order    = bus.order;
                  if (n == avail) begin
                     invalidate = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (FETCH_WIDTH=4): full and partial blocks, IQ back-pressure,
// redirects in every state and reset during an outstanding request.
module tb_fetch_unit;
   localparam int FW = 4;

   localparam logic [127:0] D1 = 128'hA1000003_A1000002_A1000001_A1000000;
   localparam logic [127:0] D2 = 128'hB2000003_B2000002_B2000001_B2000000;
   localparam logic [127:0] D3 = 128'hC3000003_C3000002_C3000001_C3000000;
   localparam logic [127:0] D4 = 128'hD4000003_D4000002_D4000001_D4000000;
   localparam logic [127:0] D5 = 128'hE5000003_E5000002_E5000001_E5000000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   fetch_unit_if #(.FETCH_WIDTH(FW)) bus ();

   fetch_unit #(.FETCH_WIDTH(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic [63:0] ord,
                                input logic br, input logic resp,
                                input logic [127:0] rdata, input logic [3:0] space);
      bus.PC         = pc;
      bus.order      = ord;
      bus.Br_valid   = br;
      bus.imem_resp  = resp;
      bus.imem_rdata = rdata;
      bus.iq_space   = space;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_push"},  128'(bus.iq_push),    128'd0);
      checkOutput({tag, "_move"},  128'(bus.move_pc),    128'd0);
      checkOutput({tag, "_rmask"}, 128'(bus.imem_rmask), 128'd0);
   endtask

   task automatic checkPush(input string tag, input logic [3:0] cnt, input logic [31:0] pc,
                            input logic [63:0] ord, input logic [127:0] inst, input int words);
      logic [127:0] mask;
      mask = (words >= 4) ? {128{1'b1}} : ((128'd1 << (32 * words)) - 128'd1);
      checkOutput({tag, "_push"},   128'(bus.iq_push),     128'd1);
      checkOutput({tag, "_move"},   128'(bus.move_pc),     128'd1);
      checkOutput({tag, "_count"},  128'(bus.iq_count),    128'(cnt));
      checkOutput({tag, "_amount"}, 128'(bus.move_amount), 128'(cnt));
      checkOutput({tag, "_pc"},     128'(bus.iq_pc),       128'(pc));
      checkOutput({tag, "_order"},  128'(bus.iq_order),    128'(ord));
      checkOutput({tag, "_inst"},   bus.iq_inst & mask,    inst & mask);
   endtask

   task automatic checkRequest(input string tag, input logic [31:0] addr);
      checkOutput({tag, "_rmask"}, 128'(bus.imem_rmask), 128'hF);
      checkOutput({tag, "_addr"},  128'(bus.imem_addr),  128'(addr));
      checkOutput({tag, "_push"},  128'(bus.iq_push),    128'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(32'h1eceb000, 64'd0, 1'b0, 1'b0, 128'd0, 4'd8);
      nextCycle();
      nextCycle();
      checkQuiet("reset");
      checkOutput("reset_addr", 128'(bus.imem_addr), 128'd0);

      // Full block, three-cycle memory latency
      rst = 1'b0;
      applyStimulus(32'h1eceb000, 64'd0, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t1_req", 32'h1eceb000);
      nextCycle();
      applyStimulus(32'h1eceb000, 64'd0, 1'b0, 1'b0, 128'd0, 4'd8);
      checkQuiet("t1_wait");
      nextCycle();
      nextCycle();
      applyStimulus(32'h1eceb000, 64'd0, 1'b0, 1'b1, D1, 4'd8);
      checkQuiet("t1_resp");
      nextCycle();
      applyStimulus(32'h1eceb000, 64'd0, 1'b0, 1'b0, 128'd0, 4'd8);
      checkPush("t1_drain", 4'd4, 32'h1eceb000, 64'd0, D1, 4);
      nextCycle();
      applyStimulus(32'h1eceb010, 64'd0, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t1_next", 32'h1eceb010);
      nextCycle();

      // One IQ slot at a time, with a full-IQ stall in the middle
      applyStimulus(32'h1eceb010, 64'd0, 1'b0, 1'b1, D2, 4'd1);
      checkQuiet("t3_resp");
      nextCycle();
      applyStimulus(32'h1eceb010, 64'd0, 1'b0, 1'b0, 128'd0, 4'd1);
      checkPush("t3_p0", 4'd1, 32'h1eceb010, 64'd0, D2, 1);
      nextCycle();
      applyStimulus(32'h1eceb014, 64'd1, 1'b0, 1'b0, 128'd0, 4'd1);
      checkPush("t3_p1", 4'd1, 32'h1eceb014, 64'd1, 128'(32'hB2000001), 1);
      nextCycle();
      applyStimulus(32'h1eceb018, 64'd2, 1'b0, 1'b0, 128'd0, 4'd0);
      checkQuiet("t3_full");
      nextCycle();
      applyStimulus(32'h1eceb018, 64'd2, 1'b0, 1'b0, 128'd0, 4'd1);
      checkPush("t3_p2", 4'd1, 32'h1eceb018, 64'd2, 128'(32'hB2000002), 1);
      nextCycle();
      applyStimulus(32'h1eceb01c, 64'd3, 1'b0, 1'b0, 128'd0, 4'd1);
      checkPush("t3_p3", 4'd1, 32'h1eceb01c, 64'd3, 128'(32'hB2000003), 1);
      nextCycle();

      // Mid-block PC: only the upper two words go out
      applyStimulus(32'h1eceb008, 64'd10, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t2_req", 32'h1eceb000);
      nextCycle();
      applyStimulus(32'h1eceb008, 64'd10, 1'b0, 1'b1, D3, 4'd8);
      nextCycle();
      applyStimulus(32'h1eceb008, 64'd10, 1'b0, 1'b0, 128'd0, 4'd8);
      checkPush("t2_drain", 4'd2, 32'h1eceb008, 64'd10, {64'd0, 64'hC3000003_C3000002}, 2);
      nextCycle();

      // Redirect while waiting: stale response is dropped, new block fetched
      applyStimulus(32'h20000000, 64'd20, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t4_req", 32'h20000000);
      nextCycle();
      applyStimulus(32'h20000000, 64'd20, 1'b1, 1'b0, 128'd0, 4'd8);
      checkQuiet("t4_br");
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b0, 128'd0, 4'd8);
      checkQuiet("t4_discard");
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b1, D1, 4'd8);
      checkQuiet("t4_stale");
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t4_newreq", 32'h30000040);
      nextCycle();

      // Redirect coinciding with the response, then redirect during DRAIN
      applyStimulus(32'h3000004c, 64'd30, 1'b1, 1'b1, D4, 4'd8);
      checkQuiet("t5_brresp");
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t5_idle1", 32'h30000040);
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b1, D4, 4'd8);
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b1, 1'b0, 128'd0, 4'd8);
      checkQuiet("t5_brdrain");
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t5_idle2", 32'h30000040);
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b1, D5, 4'd8);
      nextCycle();
      applyStimulus(32'h3000004c, 64'd30, 1'b0, 1'b0, 128'd0, 4'd8);
      checkPush("t5_last", 4'd1, 32'h3000004c, 64'd30, 128'(32'hE5000003), 1);
      nextCycle();

      // Reset with a request outstanding; the late response must be ignored
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t6_req", 32'h40000000);
      nextCycle();
      rst = 1'b1;
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b0, 128'd0, 4'd8);
      checkQuiet("t6_rst");
      nextCycle();
      rst = 1'b0;
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b0, 128'd0, 4'd0);
      checkQuiet("t6_after");
      nextCycle();
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b1, D2, 4'd0);
      checkQuiet("t6_lateresp");
      nextCycle();
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b0, 128'd0, 4'd0);
      checkQuiet("t6_post");
      nextCycle();
      applyStimulus(32'h40000000, 64'd40, 1'b0, 1'b0, 128'd0, 4'd8);
      checkRequest("t6_idle", 32'h40000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
